// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the adder request scheduler.
// Owner entries carry a requester id sized for the widest legal NREQ.
package adder_sched_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NREQ    = 2;
  localparam int DEF_ADD_LAT = 2;
  localparam int MAX_ID_W    = 2;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } owner_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters with a registered pointer.
// The pointer moves past the granted requester only when update is set.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter  int N  = DEF_NREQ,
  localparam int PW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          update,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_id
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (grant_id == PW'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/adder_req_scheduler.sv
// Shares one fixed-latency adder between NREQ requesters and
// routes each result back to the requester that issued it.
module adder_req_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NREQ    = DEF_NREQ,
  parameter  int ADD_LAT = DEF_ADD_LAT,
  localparam int IW      = id_width(NREQ)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  add_valid,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [15:0]           ops_done,
  output logic                  busy
);

  logic          hs;
  logic [IW-1:0] gnt_id;
  owner_t        pipe [ADD_LAT+1];
  owner_t        head;
  logic          any_v;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .en       (en),
    .req      (req_valid),
    .update   (hs),
    .grant    (req_ready),
    .grant_id (gnt_id)
  );

  assign hs   = |(req_valid & req_ready);
  assign head = pipe[ADD_LAT];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
    end else begin
      add_valid <= hs;
      if (hs) begin
        add_a   <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
        add_b   <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
        add_cin <= req_cin[gnt_id];
      end
    end
  end

  // Stage 0 lines up with add_valid; the last stage with add_sum.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      for (int k = 0; k <= ADD_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0].valid <= hs;
      pipe[0].id    <= MAX_ID_W'(gnt_id);
      for (int k = 1; k <= ADD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      ops_done  <= '0;
    end else begin
      rsp_valid <= head.valid ? (NREQ'(1) << head.id) : '0;
      if (head.valid) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        ops_done <= ops_done + 16'd1;
      end
    end
  end

  always_comb begin
    any_v = 1'b0;
    for (int k = 0; k <= ADD_LAT; k++) any_v = any_v | pipe[k].valid;
  end

  assign busy = any_v | add_valid;

endmodule

// File: tb/tb_adder_req_scheduler.sv
// Directed bench for adder_req_scheduler with a two-stage adder model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_adder_req_scheduler;

  localparam int W = 16;
  localparam int N = 2;
  localparam int L = 2;

  logic           clk = 1'b0;
  logic           wb_rst_n;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic           add_valid;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [15:0]    ops_done;
  logic           busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [W:0] s1 = '0;
  logic [W:0] s2 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1 <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    s2 <= s1;
  end

  assign add_sum  = s2[W-1:0];
  assign add_cout = s2[W];

  adder_req_scheduler #(.WIDTH(W), .NREQ(N), .ADD_LAT(L)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (wb_rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_valid (add_valid),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .ops_done  (ops_done),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b1;
    req_valid = '0;
    wb_rst_n = 1'b0;
    step();
    step();
    wb_rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset();
    req_a = {16'hAAAA, 16'h5555};
    req_b = {16'h1111, 16'h2222};
    req_cin = 2'b11;
    en = 1'b1;
    req_valid = '0;
    wb_rst_n = 1'b0;
    step();
    step();
    chk_cnt++;
    if (add_valid !== 1'b0)
      $display("FAIL rst_add_valid got %b want 0", add_valid);
    else pass_cnt++;
    chk_cnt++;
    if (rsp_valid !== 2'b00)
      $display("FAIL rst_rsp_valid got %b want 00", rsp_valid);
    else pass_cnt++;
    chk_cnt++;
    if ({add_a, add_b, add_cin} !== 33'd0)
      $display("FAIL rst_operands got %h want 0",
               {add_a, add_b, add_cin});
    else pass_cnt++;
    chk_cnt++;
    if ({rsp_sum, rsp_cout} !== 17'd0)
      $display("FAIL rst_rsp got %h want 0", {rsp_sum, rsp_cout});
    else pass_cnt++;
    chk_cnt++;
    if (ops_done !== 16'h0000)
      $display("FAIL rst_ops_done got %h want 0000", ops_done);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0)
      $display("FAIL rst_busy got %b want 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 2'b00)
      $display("FAIL rst_ready got %b want 00", req_ready);
    else pass_cnt++;
    wb_rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_a = {16'h0000, 16'h1234};
    req_b = {16'h0000, 16'h0001};
    req_cin = 2'b00;
    req_valid = 2'b01;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b01)
      $display("FAIL single_ready got %b want 01", req_ready);
    else pass_cnt++;
    step();
    req_valid = 2'b00;
    chk_cnt++;
    if ({add_valid, add_a, add_b, add_cin} !== {1'b1, 16'h1234, 16'h0001, 1'b0})
      $display("FAIL single_issue got %b %h %h %b want 1 1234 0001 0",
               add_valid, add_a, add_b, add_cin);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1)
      $display("FAIL single_busy got %b want 1", busy);
    else pass_cnt++;
    step();
    step();
    chk_cnt++;
    if (rsp_valid !== 2'b00)
      $display("FAIL single_early_rsp got %b want 00", rsp_valid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({rsp_valid, rsp_sum, rsp_cout} !== {2'b01, 16'h1235, 1'b0})
      $display("FAIL single_rsp got %b %h %b want 01 1235 0",
               rsp_valid, rsp_sum, rsp_cout);
    else pass_cnt++;
    chk_cnt++;
    if (ops_done !== 16'd1)
      $display("FAIL single_ops_done got %0d want 1", ops_done);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({rsp_valid, busy} !== 3'b000)
      $display("FAIL single_idle got %b %b want 00 0", rsp_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic [W-1:0] es;
    logic         ea;
    do_reset();
    req_a = {16'h0100, 16'h0010};
    req_b = {16'h0200, 16'h0005};
    req_cin = 2'b10;
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 4) ? 2'b11 : 2'b00;
      #1;
      eg = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      ea = (c >= 1 && c <= 4);
      er = (c < 4 || c > 7) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      es = (c % 2 == 0) ? 16'h0015 : 16'h0301;
      chk_cnt++;
      if (req_ready !== eg)
        $display("FAIL b2b_grant c%0d got %b want %b", c, req_ready, eg);
      else pass_cnt++;
      chk_cnt++;
      if (add_valid !== ea)
        $display("FAIL b2b_issue c%0d got %b want %b", c, add_valid, ea);
      else pass_cnt++;
      chk_cnt++;
      if (rsp_valid !== er)
        $display("FAIL b2b_rsp c%0d got %b want %b", c, rsp_valid, er);
      else pass_cnt++;
      if (er != 2'b00) begin
        chk_cnt++;
        if ({rsp_sum, rsp_cout} !== {es, 1'b0})
          $display("FAIL b2b_sum c%0d got %h %b want %h 0",
                   c, rsp_sum, rsp_cout, es);
        else pass_cnt++;
      end
      step();
    end
    chk_cnt++;
    if (ops_done !== 16'd4)
      $display("FAIL b2b_ops_done got %0d want 4", ops_done);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    req_a = {16'hFFFF, 16'h0000};
    req_b = {16'h0001, 16'h0000};
    req_cin = 2'b10;
    req_valid = 2'b10;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b10)
      $display("FAIL ovf_ready got %b want 10", req_ready);
    else pass_cnt++;
    step();
    req_valid = 2'b00;
    step();
    step();
    step();
    chk_cnt++;
    if ({rsp_valid, rsp_sum, rsp_cout} !== {2'b10, 16'h0001, 1'b1})
      $display("FAIL ovf_rsp got %b %h %b want 10 0001 1",
               rsp_valid, rsp_sum, rsp_cout);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_enable();
    do_reset();
    req_a = {16'h0BAD, 16'h0001};
    req_b = {16'h0001, 16'h0001};
    req_cin = 2'b00;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    drain();
    en = 1'b0;
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk_cnt++;
      if ({req_ready, add_valid} !== 3'b000)
        $display("FAIL en_block c%0d got %b %b want 00 0",
                 c, req_ready, add_valid);
      else pass_cnt++;
      step();
    end
    en = 1'b1;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b10)
      $display("FAIL en_resume got %b want 10", req_ready);
    else pass_cnt++;
    step();
    req_valid = 2'b00;
    chk_cnt++;
    if ({add_valid, add_a} !== {1'b1, 16'h0BAD})
      $display("FAIL en_issue got %b %h want 1 0bad", add_valid, add_a);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_a = {16'h0002, 16'h0001};
    req_b = {16'h0002, 16'h0001};
    req_cin = 2'b00;
    req_valid = 2'b11;
    step();
    step();
    req_valid = 2'b00;
    chk_cnt++;
    if ({add_valid, busy} !== 2'b11)
      $display("FAIL mid_inflight got %b %b want 1 1", add_valid, busy);
    else pass_cnt++;
    wb_rst_n = 1'b0;
    step();
    wb_rst_n = 1'b1;
    chk_cnt++;
    if ({add_valid, busy} !== 2'b00)
      $display("FAIL mid_busy got %b %b want 0 0", add_valid, busy);
    else pass_cnt++;
    for (int c = 0; c < 6; c++) begin
      chk_cnt++;
      if (rsp_valid !== 2'b00)
        $display("FAIL mid_rsp c%0d got %b want 00", c, rsp_valid);
      else pass_cnt++;
      step();
    end
    chk_cnt++;
    if (ops_done !== 16'd0)
      $display("FAIL mid_ops_done got %0d want 0", ops_done);
    else pass_cnt++;
    req_valid = 2'b11;
    #1;
    chk_cnt++;
    if (req_ready !== 2'b01)
      $display("FAIL mid_next_grant got %b want 01", req_ready);
    else pass_cnt++;
    step();
    req_valid = 2'b00;
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.ops_done = 16'hFFFE;
    #1;
    release dut.ops_done;
    req_a = {16'h0003, 16'h0004};
    req_b = {16'h0003, 16'h0004};
    req_cin = 2'b00;
    req_valid = 2'b11;
    step();
    step();
    req_valid = 2'b00;
    step();
    step();
    chk_cnt++;
    if (ops_done !== 16'hFFFF)
      $display("FAIL wrap_ffff got %h want ffff", ops_done);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ops_done !== 16'h0000)
      $display("FAIL wrap_zero got %h want 0000", ops_done);
    else pass_cnt++;
    chk_cnt++;
    if ({rsp_valid, rsp_sum} !== {2'b10, 16'h0006})
      $display("FAIL wrap_rsp got %b %h want 10 0006", rsp_valid, rsp_sum);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    wb_rst_n = 1'b0;
    en = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_enable();
    test_reset_midflight();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adder_req_scheduler.md
Name: adder_req_scheduler

Overview:
- Shares one fixed-latency adder datapath in the user project between NREQ requesters, for example the logic-analyzer probe port and the Wishbone slave port.
- Arbitrates issue slots round-robin and drives the operands into the adder.
- Tracks which requester owns each in-flight operation and routes every result back to its owner.
- Exports a completion counter for GPIO status, matching the checkbits style.

Parameters:
- WIDTH, 16, operand and sum width.
- NREQ, 2, number of requesters; legal range 2..4.
- ADD_LAT, 2, adder latency in cycles from add_valid to a valid add_sum; legal range 1..8.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_n  in  1  synchronous, active-low reset.
- en  in  1  when 0, no new grants; in-flight operations still complete.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester grant; at most one bit set.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same slicing as req_a.
- req_cin  in  NREQ  carry-in per requester.
- add_valid  out  1  issue strobe to the adder.
- add_a  out  WIDTH  operand A to the adder.
- add_b  out  WIDTH  operand B to the adder.
- add_cin  out  1  carry-in to the adder.
- add_sum  in  WIDTH  adder sum, valid ADD_LAT cycles after add_valid.
- add_cout  in  1  adder carry-out, same timing as add_sum.
- rsp_valid  out  NREQ  one-hot result strobe to the owning requester.
- rsp_sum  out  WIDTH  result sum.
- rsp_cout  out  1  result carry-out.
- ops_done  out  16  count of delivered results; wraps modulo 2^16.
- busy  out  1  at least one operation in flight.

Behaviour:
- Reset (wb_rst_n=0 at a rising edge):
  - add_valid=0, rsp_valid=0, add_a/add_b/add_cin/rsp_sum/rsp_cout=0, ops_done=0, busy=0.
  - Round-robin pointer = 0; owner pipeline cleared.
- Reset mid-operation drops every in-flight operation: no rsp_valid is produced for it and ops_done does not count it.
- Arbitration (combinational):
  - If en=1, grant the first requester with req_valid=1, searching from the pointer upward and wrapping modulo NREQ.
  - req_ready is one-hot on the granted requester; all zeros if en=0 or no request.
  - req_ready may depend on req_valid. Requesters must hold operands stable while req_valid=1.
- Handshake at edge t happens when req_valid[i] & req_ready[i].
  - Pointer becomes (i+1) mod NREQ; it is unchanged when no handshake occurs.
  - Throughput is one issue per cycle, with no bubbles.
- Issue stage (registered):
  - Cycle t+1: add_valid=1, with add_a/add_b/add_cin = requester i operands.
  - Otherwise add_valid=0 and the operand outputs hold their last values.
- Owner tracking:
  - Shift register of {valid, id}, depth ADD_LAT+1, advanced every cycle.
  - The entry written at t+1 emerges aligned with add_sum at cycle t+1+ADD_LAT.
- Response stage (registered):
  - Cycle t+2+ADD_LAT: rsp_valid[i]=1, rsp_sum=add_sum, rsp_cout=add_cout, all captured at t+1+ADD_LAT.
  - Total latency from handshake to response is ADD_LAT+2 cycles.
- Responses have no backpressure; requesters must accept them.
- ops_done increments by 1 in the cycle rsp_valid is set (same edge) and wraps 0xFFFF→0x0000.
- busy is 1 while any owner-pipeline entry is valid or add_valid=1. It does not include the response register.
- Simultaneous requests from all requesters are served strictly in rotation, so starvation is bounded by NREQ-1 grants.
- en falling mid-burst blocks the next grant only; already-issued operations still complete.
- Sum width is WIDTH; overflow appears only on rsp_cout, with no saturation.

Decomposition:
- Package adder_sched_pkg holds:
  - default WIDTH/NREQ/ADD_LAT;
  - the id width function clog2(NREQ);
  - the owner-entry struct {valid, id}.
- One sub-module, rr_arbiter: NREQ-wide round-robin grant with pointer and update input. It is reusable by later Wishbone/LA sharing blocks.
- The owner shift register and the response stage stay in the top module.

Test Plan:
- Single request: requester 0, A=0x1234, B=0x0001, cin=0, ADD_LAT=2.
  - Expect req_ready[0] in the same cycle and add_valid 1 cycle later.
  - Expect rsp_valid=2'b01 with sum=0x1235, cout=0 exactly 4 cycles after the handshake; ops_done=1.
- Both requesters held valid for 4 cycles:
  - Grants alternate 0,1,0,1.
  - Four responses arrive in the same order on consecutive cycles; ops_done=4; no bubbles.
- Overflow: A=0xFFFF, B=0x0001, cin=1 -> rsp_sum=0x0001, rsp_cout=1.
- en=0 with both requesters valid:
  - req_ready=0 and no add_valid for 10 cycles.
  - Raising en resumes with a grant to the current pointer.
- Reset mid-flight: assert wb_rst_n=0 one cycle after 2 issues.
  - No rsp_valid follows; ops_done=0; busy=0; the next grant goes to requester 0.
- Counter wrap: preload to 0xFFFE via 0xFFFE completions (or force), then 2 more operations -> ops_done reads 0x0000.
